// File: rtl/aes_pkg.sv
// AES-128 shared definitions: S-box, GF(2^8) helpers, round functions and the core FSM state type.
package aes_pkg;
  localparam int NUM_ROUNDS = 10;
  localparam int BLOCK_W    = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Column-major state: byte i sits at row i%4, column i/4, bits [127-8i -: 8].
  function automatic logic [127:0] sub_shift(input logic [127:0] st);
    logic [127:0] o;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = SBOX[st[127 - 8*(4*((c + r) % 4) + r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] execute_round(input logic [127:0] st, input logic [127:0] rk);
    logic [127:0] t;
    t = sub_shift(st);
    return {mix_column(t[127:96]), mix_column(t[95:64]), mix_column(t[63:32]), mix_column(t[31:0])} ^ rk;
  endfunction

  function automatic logic [127:0] execute_last_round(input logic [127:0] st, input logic [127:0] rk);
    return sub_shift(st) ^ rk;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: derives the next round key from the current one and rcon.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  output logic [127:0] key_out
);
  logic [31:0] temp_s, w0_s, w1_s, w2_s, w3_s;

  assign temp_s  = sub_word({key_in[23:0], key_in[31:24]}) ^ {rcon_in, 24'h000000};
  assign w0_s    = key_in[127:96] ^ temp_s;
  assign w1_s    = key_in[95:64]  ^ w0_s;
  assign w2_s    = key_in[63:32]  ^ w1_s;
  assign w3_s    = key_in[31:0]   ^ w2_s;
  assign key_out = {w0_s, w1_s, w2_s, w3_s};
endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock, on-the-fly key schedule, one block in flight.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext_in,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               busy
);
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] RND_STEP = 4'(UNROLL);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - UNROLL);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] blk_q, blk_d, key_q, key_d, ct_q, ct_d;
  logic [TAG_W-1:0]   tag_q, tag_d, tag_out_q, tag_out_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [7:0]         rcon_q, rcon_d;
  logic               out_valid_q, out_valid_d;
  logic               accept_s, last_cycle_s;

  logic [BLOCK_W-1:0] blk_chain_s  [UNROLL+1];
  logic [BLOCK_W-1:0] key_chain_s  [UNROLL+1];
  logic [7:0]         rcon_chain_s [UNROLL+1];

  assign in_ready       = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_s       = in_valid && in_ready;
  assign last_cycle_s   = (rnd_q == LAST_RND);
  assign busy           = (state_q != ST_IDLE);
  assign out_valid      = out_valid_q;
  assign ciphertext_out = ct_q;
  assign tag_out        = tag_out_q;

  assign blk_chain_s[0]  = blk_q;
  assign key_chain_s[0]  = key_q;
  assign rcon_chain_s[0] = rcon_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    aes_key_step u_key_step (
      .key_in  (key_chain_s[i]),
      .rcon_in (rcon_chain_s[i]),
      .key_out (key_chain_s[i+1])
    );
    assign rcon_chain_s[i+1] = xtime(rcon_chain_s[i]);
    // Only the final stage can host round 10, and only on the last cycle of a block.
    if (i == UNROLL - 1) begin : g_tail
      assign blk_chain_s[i+1] = last_cycle_s ? execute_last_round(blk_chain_s[i], key_chain_s[i+1])
                                             : execute_round(blk_chain_s[i], key_chain_s[i+1]);
    end else begin : g_body
      assign blk_chain_s[i+1] = execute_round(blk_chain_s[i], key_chain_s[i+1]);
    end
  end

  // Next-state, datapath and output-register update.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    key_d       = key_q;
    tag_d       = tag_q;
    rnd_d       = rnd_q;
    rcon_d      = rcon_q;
    ct_d        = ct_q;
    tag_out_d   = tag_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        blk_d  = blk_chain_s[UNROLL];
        key_d  = key_chain_s[UNROLL];
        rcon_d = rcon_chain_s[UNROLL];
        rnd_d  = rnd_q + RND_STEP;
        if (last_cycle_s) begin
          ct_d        = blk_chain_s[UNROLL];
          tag_out_d   = tag_q;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    // An accept in DONE overrides the return to IDLE so back-to-back blocks lose no cycle.
    if (accept_s) begin
      blk_d   = plaintext_in ^ key_in;
      key_d   = key_in;
      tag_d   = tag_in;
      rnd_d   = 4'd0;
      rcon_d  = 8'h01;
      state_d = ST_RUN;
    end else begin
      tag_d = tag_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      blk_q       <= 128'd0;
      key_q       <= 128'd0;
      tag_q       <= '0;
      rnd_q       <= 4'd0;
      rcon_q      <= 8'h00;
      ct_q        <= 128'd0;
      tag_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      tag_q       <= tag_d;
      rnd_q       <= rnd_d;
      rcon_q      <= rcon_d;
      ct_q        <= ct_d;
      tag_out_q   <= tag_out_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Sequential AES-128 encryption core with valid/ready handshakes on both sides.
- Replaces the fully unrolled combinational encryptor where area or timing matters.
- Computes UNROLL rounds per clock, generates round keys on the fly, and carries a caller tag through with each block.
- Sits between a block-source FIFO/DMA and the ciphertext sink; one block in flight at a time.

Parameters:
- UNROLL, 1: rounds computed per clock. Legal values are 1, 2, 5, 10; any other value is an elaboration error.
- TAG_W, 4: width of the user tag carried with each block.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  plaintext/key/tag present
- in_ready  out  1  core can accept a block this cycle
- plaintext_in  in  128  plaintext block, byte 0 = bits [127:120]
- key_in  in  128  cipher key for this block
- tag_in  in  TAG_W  user tag
- out_valid  out  1  ciphertext_out/tag_out valid
- out_ready  in  1  sink accepts result
- ciphertext_out  out  128  ciphertext block
- tag_out  out  TAG_W  tag of the accepted block
- busy  out  1  high in RUN or DONE

Behaviour:
- Clock and reset are decided: one clock named clk; reset named rst_n, asynchronous and active-low.
- Reset values: state IDLE; out_valid=0; in_ready=1 (combinational, derived from IDLE); busy=0. ciphertext_out, tag_out, state reg, key reg, round counter and rcon are all 0.
- FSM has three states: IDLE, RUN, DONE.
- Accept: in_valid && in_ready at a rising edge.
  - state_reg <= plaintext_in ^ key_in; key_reg <= key_in; tag_reg <= tag_in.
  - rnd <= 0; rcon <= 8'h01; go to RUN.
- RUN, each clock: apply UNROLL rounds combinationally.
  - Each round = key step (derive next round key from key_reg and rcon), then SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10 omits MixColumns.
  - rnd advances by UNROLL.
  - rcon advances UNROLL times by xtime: 01,02,04,08,10,20,40,80,1b,36.
  - When rnd+UNROLL == 10: write result to ciphertext_out and tag_reg to tag_out; set out_valid=1; go to DONE.
- Latency: out_valid rises exactly 10/UNROLL cycles after the accept edge (10, 5, 2 or 1).
- DONE:
  - ciphertext_out, tag_out and out_valid hold stable until out_valid && out_ready.
  - On that handshake, out_valid clears and the FSM returns to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Simultaneous output handshake and input accept in DONE: the new block loads and the FSM goes straight to RUN.
  - out_valid clears the same edge.
  - Back-to-back throughput: one block per 10/UNROLL+1 cycles.
- Inputs are sampled only at the accept edge. Changes to plaintext_in/key_in/tag_in during RUN or DONE have no effect.
- in_valid may drop without a handshake (no input stickiness required). out_valid must never drop without a handshake.
- out_ready asserted while not in DONE is ignored.
- Asynchronous reset mid-RUN or mid-DONE: the block is discarded, all registers return to reset values, and no out_valid is produced.
- rnd is a 4-bit counter; it never exceeds 10. All byte arithmetic is GF(2^8) with polynomial 0x11b.

Decomposition:
- Package aes_pkg:
  - S-box constant array.
  - xtime function.
  - NUM_ROUNDS=10 and BLOCK_W=128 constants.
  - FSM state enum.
- Sub-module aes_key_step:
  - Inputs: 128-bit key and 8-bit rcon.
  - Output: next 128-bit round key (RotWord, SubWord, rcon XOR, word chaining).
  - Instantiated UNROLL times in the datapath chain, alongside the existing execute_round / execute_last_round round logic.
  - Round UNROLL-th stage selects last-round behaviour only on the final cycle.

Test Plan:
- FIPS-197 App. C.1 vector, UNROLL=1:
  - Stimulus: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, tag 3.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, tag_out 3.
  - Required: out_valid exactly 10 cycles after accept.
- FIPS-197 App. B vector, UNROLL=1,2,5,10:
  - Stimulus: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required latency: 10, 5, 2, 1 cycles respectively.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid; change inputs meanwhile.
  - Required: outputs stable, in_ready=0.
  - Required: on out_ready=1, one handshake, then in_ready=1.
- Back-to-back:
  - Stimulus: in_valid held with zero pt/key then App. B vector; out_ready=1.
  - Required: 66e94bd4ef8a2c3b884cfa59ca342b2e then 3925841d...
  - Required: second accept on same edge as first output handshake.
- Reset mid-RUN:
  - Stimulus: assert rst_n=0 at cycle 4 of a block, asynchronous to clk.
  - Required: out_valid=0 immediately, busy=0, in_ready=1 after release.
  - Required: next block encrypts correctly.
- Tag passthrough:
  - Stimulus: eight blocks with tags 0..7 (TAG_W=4), random out_ready.
  - Required: tag_out sequence 0..7 matches the ciphertexts from a software model.
